// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int BYTE_LANES = 4;
  localparam int WORD_BITS  = 32;
  localparam int WS_BITS    = 4;

endpackage

// File: rtl/dmem_bank.sv
// Byte-writeable synchronous word RAM with a registered read port.
// The read register returns zero on cycles without a read so it can drive
// the response data bus directly.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [BYTE_LANES-1:0] be,
  input  logic                  rd_en,
  input  logic [AW-1:0]         addr,
  input  logic [WORD_BITS-1:0]  wdata,
  output logic [WORD_BITS-1:0]  rdata
);

  logic [WORD_BITS-1:0] mem [DEPTH_WORDS];

  // Storage array: only the enabled byte lanes are written; never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read register: holds the sampled word for one cycle, zero otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data-memory responder: one request at a time, configurable
// wait states, byte-lane stores, range checking and a stall to the hazard unit.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [WORD_BITS-1:0]  req_wdata,
  input  logic [BYTE_LANES-1:0] req_be,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [WORD_BITS-1:0]  rsp_rdata,
  output logic                  rsp_err,
  output logic                  stall
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_t state, next_state;

  logic [WS_BITS-1:0]    cnt;
  logic                  lat_write;
  logic [29:0]           lat_idx;
  logic [WORD_BITS-1:0]  lat_wdata;
  logic [BYTE_LANES-1:0] lat_be;

  logic                  accept;
  logic                  commit;
  logic                  cur_write;
  logic [29:0]           cur_idx;
  logic [WORD_BITS-1:0]  cur_wdata;
  logic [BYTE_LANES-1:0] cur_be;
  logic                  in_range;
  logic                  bank_wr;
  logic                  bank_rd;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus handshake, stall and commit strobes.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    stall      = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            commit     = 1'b1;
            next_state = RESP;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt <= WS_BITS'(1)) begin
          commit     = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // With zero wait states the commit happens on the acceptance edge, so the
  // commit fields come straight from the request while still in IDLE.
  always_comb begin
    cur_write = lat_write;
    cur_idx   = lat_idx;
    cur_wdata = lat_wdata;
    cur_be    = lat_be;
    if (state == IDLE) begin
      cur_write = req_write;
      cur_idx   = req_addr[31:2];
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end
  end

  assign in_range = ((cur_idx >> AW) == '0);
  assign bank_wr  = commit && cur_write && in_range;
  assign bank_rd  = commit && !cur_write && in_range;

  // Request latch and wait-state counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (accept) begin
      cnt       <= WS_BITS'(WAIT_STATES);
      lat_write <= req_write;
      lat_idx   <= req_addr[31:2];
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end else if (state == WAIT) begin
      cnt <= cnt - WS_BITS'(1);
    end
  end

  // Response strobe and error flag, registered on the commit edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= commit;
      rsp_err   <= commit && !in_range;
    end
  end

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .wr_en (bank_wr),
    .be    (cur_be),
    .rd_en (bank_rd),
    .addr  (cur_idx[AW-1:0]),
    .wdata (cur_wdata),
    .rdata (rsp_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: instance a runs with two wait states, instance b with
// none; responses are compared against a word-array model of the memory.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_a, valid_b;
  logic        req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        ready_a, rv_a, err_a, stall_a;
  logic [31:0] rdata_a;
  logic        ready_b, rv_b, err_b, stall_b;
  logic [31:0] rdata_b;

  bit          which_sel;
  logic        s_ready, s_rv, s_err, s_stall;
  logic [31:0] s_rdata;

  int checks = 0;
  int fails  = 0;

  logic [31:0] model_a [int];
  logic [31:0] model_b [int];

  always #5 clk = ~clk;

  assign s_ready = which_sel ? ready_b : ready_a;
  assign s_rv    = which_sel ? rv_b    : rv_a;
  assign s_err   = which_sel ? err_b   : err_a;
  assign s_stall = which_sel ? stall_b : stall_a;
  assign s_rdata = which_sel ? rdata_b : rdata_a;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut_a (
    .clk(clk), .reset(reset), .req_valid(valid_a), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .req_ready(ready_a), .rsp_valid(rv_a), .rsp_rdata(rdata_a),
    .rsp_err(err_a), .stall(stall_a)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(valid_b), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .req_ready(ready_b), .rsp_valid(rv_b), .rsp_rdata(rdata_b),
    .rsp_err(err_b), .stall(stall_b)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // One complete request on the selected instance, checked against the model.
  task automatic do_txn(input bit which, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input bit mutate, input string name);
    int          ws;
    int          lat;
    int          stall_cyc;
    bit          got;
    bit          exp_err;
    int          idx;
    logic [31:0] exp_data;
    logic [31:0] old_w;
    ws        = which ? 0 : 2;
    exp_err   = (addr[31:2] >= 30'(DEPTH));
    idx       = exp_err ? -1 : int'(addr[31:2]);
    exp_data  = 32'h0;
    old_w     = 32'h0;
    if (!exp_err) begin
      if (which && model_b.exists(idx)) old_w = model_b[idx];
      if (!which && model_a.exists(idx)) old_w = model_a[idx];
    end
    if (!wr && !exp_err) exp_data = old_w;
    which_sel = which;
    @(negedge clk);
    checks++;
    if (s_rv !== 1'b0) begin
      fails++; $display("[TB] FAIL %s idle_rsp_low: got %b want 0", name, s_rv);
    end
    req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
    if (which) valid_b = 1'b1; else valid_a = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1 || s_stall !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s accept_cycle: ready=%b stall=%b want 1/1", name, s_ready, s_stall);
    end
    stall_cyc = 1;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (s_rv === 1'b1) got = 1'b1;
      else if (s_stall === 1'b1) stall_cyc++;
      if (mutate && lat == 1) begin
        req_addr  = addr ^ 32'h0000_000C;
        req_wdata = ~wd;
        req_be    = ~be;
        req_write = ~wr;
      end
    end
    checks++;
    if (!got) begin
      fails++; $display("[TB] FAIL %s timeout: no rsp_valid within 40 cycles", name);
    end else begin
      checks += 5;
      if (lat != ws + 1) begin
        fails++; $display("[TB] FAIL %s latency: got %0d want %0d", name, lat, ws + 1);
      end
      if (stall_cyc != ws + 1) begin
        fails++; $display("[TB] FAIL %s stall_cycles: got %0d want %0d", name, stall_cyc, ws + 1);
      end
      if (s_stall !== 1'b0 || s_ready !== 1'b0) begin
        fails++;
        $display("[TB] FAIL %s rsp_cycle_hs: stall=%b ready=%b want 0/0", name, s_stall, s_ready);
      end
      if (s_err !== exp_err) begin
        fails++; $display("[TB] FAIL %s rsp_err: got %b want %b", name, s_err, exp_err);
      end
      if (s_rdata !== exp_data) begin
        fails++; $display("[TB] FAIL %s rsp_rdata: got %h want %h", name, s_rdata, exp_data);
      end
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    if (wr && !exp_err) begin
      if (which) model_b[idx] = merge(old_w, wd, be);
      else model_a[idx] = merge(old_w, wd, be);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (rv_a !== 1'b0 || rdata_a !== 32'h0 || err_a !== 1'b0 || ready_a !== 1'b1 || stall_a !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_a: rv=%b rdata=%h err=%b ready=%b stall=%b", rv_a, rdata_a, err_a, ready_a, stall_a);
    end
    checks++;
    if (rv_b !== 1'b0 || rdata_b !== 32'h0 || err_b !== 1'b0 || ready_b !== 1'b1 || stall_b !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_b: rv=%b rdata=%h err=%b ready=%b stall=%b", rv_b, rdata_b, err_b, ready_b, stall_b);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_init();
    for (int i = 0; i < 16; i++)
      do_txn(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, "init_a");
    for (int i = 0; i < 4; i++)
      do_txn(1'b1, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, "init_b");
  endtask

  task automatic test_basic();
    do_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "basic_store");
    do_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, "basic_load");
  endtask

  task automatic test_byte_lanes();
    do_txn(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, "lanes_full");
    do_txn(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, "lanes_partial");
    do_txn(1'b0, 1'b1, 32'h22, 32'h99999999, 4'b0000, 1'b0, "lanes_none");
    do_txn(1'b0, 1'b0, 32'h23, 32'h0, 4'h0, 1'b0, "lanes_load");
    checks++;
    if (model_a[8] !== 32'h11BB33DD) begin
      fails++; $display("[TB] FAIL lanes_model: got %h want 11bb33dd", model_a[8]);
    end
  endtask

  task automatic test_out_of_range();
    do_txn(1'b0, 1'b1, 32'h400, 32'h12345678, 4'hF, 1'b0, "oor_store");
    do_txn(1'b0, 1'b0, 32'h400, 32'h0, 4'h0, 1'b0, "oor_load");
    do_txn(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, "oor_word0");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    d = $urandom;
    which_sel = 1'b1;
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h8; req_wdata = d; req_be = 4'hF; valid_b = 1'b1;
    @(negedge clk);
    checks++;
    if (rv_b !== 1'b1 || err_b !== 1'b0 || stall_b !== 1'b0) begin
      fails++; $display("[TB] FAIL b2b_store_rsp: rv=%b err=%b stall=%b want 1/0/0", rv_b, err_b, stall_b);
    end
    req_write = 1'b0;
    @(negedge clk);
    checks++;
    if (rv_b !== 1'b0 || ready_b !== 1'b1 || stall_b !== 1'b1) begin
      fails++; $display("[TB] FAIL b2b_gap: rv=%b ready=%b stall=%b want 0/1/1", rv_b, ready_b, stall_b);
    end
    @(negedge clk);
    checks++;
    if (rv_b !== 1'b1 || rdata_b !== d) begin
      fails++; $display("[TB] FAIL b2b_load_rsp: rv=%b rdata=%h want 1/%h", rv_b, rdata_b, d);
    end
    valid_b = 1'b0;
    model_b[2] = d;
  endtask

  task automatic test_reset_in_wait();
    do_txn(1'b0, 1'b1, 32'h30, 32'h0, 4'hF, 1'b0, "rst_prep");
    which_sel = 1'b0;
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_be = 4'hF; valid_a = 1'b1;
    @(negedge clk);
    reset = 1'b0; valid_a = 1'b0;
    #1;
    checks++;
    if (rv_a !== 1'b0 || rdata_a !== 32'h0 || err_a !== 1'b0 || ready_a !== 1'b1 || stall_a !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rst_wait_outputs: rv=%b rdata=%h err=%b ready=%b stall=%b", rv_a, rdata_a, err_a, ready_a, stall_a);
    end
    @(negedge clk);
    reset = 1'b1;
    do_txn(1'b0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, "rst_reload");
  endtask

  task automatic test_field_change();
    do_txn(1'b0, 1'b1, 32'h4, 32'h5A5A1234, 4'hF, 1'b1, "chg_store");
    do_txn(1'b0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, "chg_load4");
    do_txn(1'b0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, "chg_load8");
  endtask

  task automatic test_random();
    logic [31:0] a;
    bit          wr;
    bit          which;
    for (int n = 0; n < 40; n++) begin
      which = ($urandom_range(0, 3) == 0);
      wr    = $urandom_range(0, 1);
      if (!which && $urandom_range(0, 7) == 0)
        a = 32'((256 + $urandom_range(0, 1000)) * 4);
      else
        a = 32'($urandom_range(0, which ? 3 : 15) * 4);
      a = a | 32'($urandom_range(0, 3));
      do_txn(which, wr, a, $urandom, 4'($urandom_range(0, 15)), 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_basic();
    test_byte_lanes();
    test_out_of_range();
    test_back_to_back();
    test_reset_in_wait();
    test_field_change();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
